// File: rtl/fsk_bit_decider_pkg.sv
// Shared definitions for the FSK bit decider and the analyzer wrapper:
// demodulation FSM state encoding and the window/evidence derivations.
package fsk_bit_decider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR       = 3'd1,
    ST_INTEGRATE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_DECIDE    = 3'd4
  } fsk_state_e;

  // Cycles the analyzer needs for its registered accumulation to land.
  localparam int unsigned SETTLE_CYCLES = 2;

  function automatic int unsigned calc_window_ticks(input int unsigned clock_frequency,
                                                    input int unsigned bit_rate);
    return clock_frequency / bit_rate;
  endfunction

  function automatic int unsigned calc_min_evidence(input int unsigned window_ticks,
                                                    input int unsigned percent);
    return window_ticks * percent / 100;
  endfunction

  // Counter must reach WINDOW_TICKS-1 and SETTLE_CYCLES-1.
  function automatic int unsigned calc_count_width(input int unsigned window_ticks);
    return (window_ticks > 2) ? $clog2(window_ticks) : 1;
  endfunction

endpackage

// File: rtl/fsk_bit_decider_if.sv
// Decided-bit stream: bit_data/bit_error qualified by bit_valid, accepted
// with bit_ready. master = bit source (decider), slave = bit consumer.
interface fsk_bit_decider_if;
  logic bit_data;
  logic bit_error;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_data, output bit_error, output bit_valid, input bit_ready);
  modport slave  (input bit_data, input bit_error, input bit_valid, output bit_ready);
endinterface

// File: rtl/fsk_bit_buffer.sv
// Single-entry valid/ready output register with sticky overrun.
// Ports: clock, clear (async active-low), load/load_data/load_error (new
// decision), bit_if (master side of the bit stream), overrun (sticky).
module fsk_bit_buffer (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic load_data,
  input  logic load_error,
  fsk_bit_decider_if.master bit_if,
  output logic overrun
);

  logic valid_q;
  logic data_q;
  logic error_q;
  logic overrun_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      valid_q   <= 1'b0;
      data_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (load) begin
      // A load is accepted when the slot is empty or is being drained on
      // this same edge; otherwise the held bit wins and the new one is lost.
      if (!valid_q || bit_if.bit_ready) begin
        valid_q <= 1'b1;
        data_q  <= load_data;
        error_q <= load_error;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && bit_if.bit_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bit_if.bit_valid = valid_q;
  assign bit_if.bit_data  = data_q;
  assign bit_if.bit_error = error_q;
  assign overrun          = overrun_q;

endmodule

// File: rtl/fsk_bit_decider.sv
// FSK bit decider: sequences the upstream frequency analyzer through
// clear / integrate / settle windows, compares the symbol-0 and symbol-1
// evidence at the end of each window and emits one decided bit per window.
// Ports: clock, clear (async active-low), enable, f0_value/f1_value
// (analyzer accumulators), analyzer_clear (active-low), analyzer_enable,
// bit_if (decided-bit stream, master), overrun (sticky, cleared by reset).
module fsk_bit_decider
  import fsk_bit_decider_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY      = 50000000,
  parameter int unsigned BIT_RATE             = 1000,
  parameter int unsigned MIN_EVIDENCE_PERCENT = 25
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  output logic        analyzer_clear,
  output logic        analyzer_enable,
  fsk_bit_decider_if.master bit_if,
  output logic        overrun
);

  localparam int unsigned WINDOW_TICKS = calc_window_ticks(CLOCK_FREQUENCY, BIT_RATE);
  localparam int unsigned MIN_EVIDENCE = calc_min_evidence(WINDOW_TICKS, MIN_EVIDENCE_PERCENT);
  localparam int unsigned CNT_W        = calc_count_width(WINDOW_TICKS);

  localparam logic [CNT_W-1:0] LAST_TICK   = CNT_W'(WINDOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

  fsk_state_e       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             load;

  logic [32:0] total;
  logic        decide_error;
  logic        decide_data;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = '0;
    load       = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      state_next = ST_CLR;
        ST_CLR:       state_next = ST_INTEGRATE;
        ST_INTEGRATE: begin
          if (count == LAST_TICK) state_next = ST_SETTLE;
          else                    count_next = count + 1'b1;
        end
        ST_SETTLE: begin
          if (count == LAST_SETTLE) state_next = ST_DECIDE;
          else                      count_next = count + 1'b1;
        end
        ST_DECIDE: begin
          load       = 1'b1;
          state_next = ST_CLR;
        end
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Gated by clear so the analyzer is held in clear for the whole reset,
  // not only from the first edge after it.
  assign analyzer_clear  = clear && (state != ST_CLR);
  assign analyzer_enable = (state == ST_INTEGRATE);

  // 33-bit sum so two large accumulators cannot wrap below the threshold.
  assign total        = {1'b0, f0_value} + {1'b0, f1_value};
  assign decide_error = (total < 33'(MIN_EVIDENCE)) || (f0_value == f1_value);
  assign decide_data  = !decide_error && (f1_value > f0_value);

  fsk_bit_buffer u_buffer (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .load_data  (decide_data),
    .load_error (decide_error),
    .bit_if     (bit_if),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_fsk_bit_decider.sv
module tb_fsk_bit_decider;

  localparam int WIN    = 104;  // WINDOW_TICKS + 4
  localparam int WTICKS = 100;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic        analyzer_clear;
  logic        analyzer_enable;
  logic        overrun;

  fsk_bit_decider_if bit_if ();

  fsk_bit_decider #(
    .CLOCK_FREQUENCY      (1000),
    .BIT_RATE             (10),
    .MIN_EVIDENCE_PERCENT (25)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .enable          (enable),
    .f0_value        (f0_value),
    .f1_value        (f1_value),
    .analyzer_clear  (analyzer_clear),
    .analyzer_enable (analyzer_enable),
    .bit_if          (bit_if),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] f0;
    logic [31:0] f1;
    logic        d;
    logic        e;
  } vec_t;

  typedef struct {
    logic v1;
    logic vmid;
    logic vend;
    logic dend;
    logic eend;
    logic oend;
    logic clrend;
    int   en;
  } win_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clr();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!analyzer_clear) begin
        found = 1'b1;
        break;
      end
    end
    chk("clr_pulse_found", 64'(found), 64'd1);
  endtask

  // Starts on the negedge sample of a CLR cycle (offset 0), ends on the
  // sample of the next CLR cycle (offset WIN).
  // rdy_mode: 0 keep bit_ready, 1 drop it after offset 1, 2 raise it just
  // before the edge that ends DECIDE.
  task automatic run_window(input logic [31:0] f0, input logic [31:0] f1,
                            input int rdy_mode, output win_t w);
    w.v1 = 0; w.vmid = 0; w.vend = 0; w.dend = 0; w.eend = 0;
    w.oend = 0; w.clrend = 0; w.en = 0;
    f0_value = f0;
    f1_value = f1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clock);
      if (analyzer_enable) w.en++;
      if (k == 1)  w.v1   = bit_if.bit_valid;
      if (k == 50) w.vmid = bit_if.bit_valid;
      if (k == WIN) begin
        w.vend   = bit_if.bit_valid;
        w.dend   = bit_if.bit_data;
        w.eend   = bit_if.bit_error;
        w.oend   = overrun;
        w.clrend = !analyzer_clear;
      end
      if (k == 1 && rdy_mode == 1)       bit_if.bit_ready = 1'b0;
      if (k == WIN-1 && rdy_mode == 2)   bit_if.bit_ready = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_aclr"},    64'(analyzer_clear),   64'd0);
    chk({tag, "_aen"},     64'(analyzer_enable),  64'd0);
    chk({tag, "_valid"},   64'(bit_if.bit_valid), 64'd0);
    chk({tag, "_data"},    64'(bit_if.bit_data),  64'd0);
    chk({tag, "_error"},   64'(bit_if.bit_error), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun),          64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    win_t w;
    logic seen_valid;
    logic seen_aen;

    vecs[0] = '{f0: 32'd10,         f1: 32'd60,         d: 1'b1, e: 1'b0};
    vecs[1] = '{f0: 32'd40,         f1: 32'd40,         d: 1'b0, e: 1'b1};
    vecs[2] = '{f0: 32'd10,         f1: 32'd10,         d: 1'b0, e: 1'b1};
    vecs[3] = '{f0: 32'hFFFF_FFFF,  f1: 32'd1,          d: 1'b0, e: 1'b0};
    vecs[4] = '{f0: 32'd1,          f1: 32'hFFFF_FFFF,  d: 1'b1, e: 1'b0};
    vecs[5] = '{f0: 32'd12,         f1: 32'd13,         d: 1'b1, e: 1'b0};
    vecs[6] = '{f0: 32'd13,         f1: 32'd11,         d: 1'b0, e: 1'b1};
    vecs[7] = '{f0: 32'd70,         f1: 32'd5,          d: 1'b0, e: 1'b0};

    clear            = 1'b0;
    enable           = 1'b0;
    f0_value         = '0;
    f1_value         = '0;
    bit_if.bit_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");

    clear  = 1'b1;
    enable = 1'b1;
    wait_clr();

    foreach (vecs[i]) begin
      run_window(vecs[i].f0, vecs[i].f1, 0, w);
      chk($sformatf("v%0d_window_ticks", i), 64'(w.en),     64'(WTICKS));
      chk($sformatf("v%0d_period", i),       64'(w.clrend), 64'd1);
      chk($sformatf("v%0d_valid_k1", i),     64'(w.v1),     64'd0);
      chk($sformatf("v%0d_valid", i),        64'(w.vend),   64'd1);
      chk($sformatf("v%0d_data", i),         64'(w.dend),   64'(vecs[i].d));
      chk($sformatf("v%0d_error", i),        64'(w.eend),   64'(vecs[i].e));
    end

    // Back-pressure: hold the first bit, lose the second, then accept a
    // third on the same edge the held one drains.
    run_window(32'd10, 32'd60, 1, w);
    chk("ovr_a_valid",   64'(w.vend), 64'd1);
    chk("ovr_a_data",    64'(w.dend), 64'd1);
    chk("ovr_a_overrun", 64'(w.oend), 64'd0);
    run_window(32'd60, 32'd10, 0, w);
    chk("ovr_b_held_mid", 64'(w.vmid), 64'd1);
    chk("ovr_b_valid",    64'(w.vend), 64'd1);
    chk("ovr_b_data",     64'(w.dend), 64'd1);
    chk("ovr_b_overrun",  64'(w.oend), 64'd1);
    run_window(32'd60, 32'd10, 2, w);
    chk("ovr_c_valid",   64'(w.vend), 64'd1);
    chk("ovr_c_data",    64'(w.dend), 64'd0);
    chk("ovr_c_error",   64'(w.eend), 64'd0);
    chk("ovr_c_overrun", 64'(w.oend), 64'd1);
    @(negedge clock);
    chk("ovr_c_drained", 64'(bit_if.bit_valid), 64'd0);

    // enable dropped mid-INTEGRATE (now at offset 1 of a window).
    repeat (49) @(negedge clock);
    chk("en_drop_integrating", 64'(analyzer_enable), 64'd1);
    enable = 1'b0;
    @(negedge clock);
    chk("en_drop_aen",  64'(analyzer_enable), 64'd0);
    chk("en_drop_aclr", 64'(analyzer_clear),  64'd1);
    seen_valid = 1'b0;
    seen_aen   = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (bit_if.bit_valid) seen_valid = 1'b1;
      if (analyzer_enable)  seen_aen   = 1'b1;
    end
    chk("en_drop_no_valid", 64'(seen_valid), 64'd0);
    chk("en_drop_idle_aen", 64'(seen_aen),   64'd0);
    chk("overrun_sticky",   64'(overrun),    64'd1);

    // clear pulsed mid-INTEGRATE.
    enable = 1'b1;
    wait_clr();
    repeat (40) @(negedge clock);
    clear = 1'b0;
    #1;
    chk_reset_outputs("midclr");
    @(negedge clock);
    clear = 1'b1;
    wait_clr();
    run_window(32'd10, 32'd60, 0, w);
    chk("restart_window_ticks", 64'(w.en),     64'(WTICKS));
    chk("restart_period",       64'(w.clrend), 64'd1);
    chk("restart_no_partial",   64'(w.v1),     64'd0);
    chk("restart_valid",        64'(w.vend),   64'd1);
    chk("restart_data",         64'(w.dend),   64'd1);
    chk("restart_overrun",      64'(w.oend),   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
